btn_debounce: RTL and testbench
===============================

Name: btn_debounce

Overview:
Front-end conditioner for the four raw board push-buttons. It feeds the cleaned level bus directly into the btn_in input of the button/interrupt peripheral.
- 2-FF synchronizes each raw input.
- Debounces each input with a per-channel settle-check state machine.
- Emits one-cycle press/release pulses and a long-press level per button.

Parameters:
N_BTN, 4, number of button channels
SETTLE_CYCLES, 1000000, cycles the synchronized input must stay constant before a level change is accepted (10 ms at 100 MHz); legal range >= 1
LONG_CYCLES, 100000000, cycles in the pressed state before long_press asserts (1 s at 100 MHz); legal range >= 1
Counter widths are derived internally via $clog2 and are not parameters.

Ports:
clk  input  1  100 MHz system clock
rst  input  1  reset, synchronous, active-high
btn_raw  input  N_BTN  raw asynchronous button pins, 1 = pressed
btn_out  output  N_BTN  debounced level, 1 = pressed; drives downstream btn_in
press_pulse  output  N_BTN  one-cycle pulse on an accepted 0->1 change
release_pulse  output  N_BTN  one-cycle pulse on an accepted 1->0 change
long_press  output  N_BTN  level, high while held for >= LONG_CYCLES

Behaviour:
- Reset: sync flops, btn_out, press_pulse, release_pulse and long_press = 0. All channels enter REL. Counters = 0.
- Synchronizer: s1 <= btn_raw; s2 <= s1. The FSM sees only s2.
- Per-channel FSM (channels fully independent):
  - REL: btn_out = 0. If s2 = 1, go to PCHK and load settle counter with SETTLE_CYCLES-1.
  - PCHK:
    - s2 = 0: go back to REL. No output change, no pulse.
    - s2 = 1 and counter != 0: decrement.
    - s2 = 1 and counter = 0: go to PRS. btn_out <= 1, press_pulse <= 1 for one cycle, long counter <= 0.
  - PRS: btn_out = 1.
    - Long counter increments, saturating at LONG_CYCLES.
    - long_press <= 1 when counter reaches LONG_CYCLES-1 (i.e. on the LONG_CYCLES-th cycle in PRS).
    - If s2 = 0, go to RCHK and load settle counter with SETTLE_CYCLES-1. long_press holds its value during RCHK.
  - RCHK:
    - s2 = 1: go back to PRS. Long counter continues, no pulse.
    - s2 = 0 and counter != 0: decrement.
    - s2 = 0 and counter = 0: go to REL. btn_out <= 0, release_pulse <= 1 for one cycle, long_press <= 0, long counter <= 0.
- Latency: count the edge that first captures a new raw level into s1 as edge 1.
  - For a clean change, btn_out and the pulse update at edge SETTLE_CYCLES+3.
  - Any reversion of s2 during a CHK state restarts the whole process.
- Pulses are registered and never high for two consecutive cycles on the same channel.
- Simultaneous changes on several channels: each channel is handled independently. Equal timing produces same-edge updates on all of them.
- Button held through reset: after rst deasserts, the press is detected normally from REL and a press_pulse is generated.
- rst asserted mid-CHK or mid-PRS: immediate return to the reset state. No release_pulse is generated.
- All outputs are registered; there is no combinational path from btn_raw to any output.

Decomposition:
- Package btn_pkg holds:
  - the 2-bit state encoding: REL = 0, PCHK = 1, PRS = 2, RCHK = 3
  - the default N_BTN
- Sub-module btn_debounce_ch:
  - contains one synchronizer, one FSM, the settle counter and the long counter
  - parameters SETTLE_CYCLES and LONG_CYCLES
- The top level instantiates btn_debounce_ch N_BTN times in a generate loop.

Test Plan:
(Sim parameters: SETTLE_CYCLES = 8, LONG_CYCLES = 32.)
1. Clean press: btn_raw[0] 0->1 captured at edge 1 -> btn_out = 4'b0001 and press_pulse[0] high for exactly one cycle at edge 11. No other channel changes.
2. Bounce: btn_raw[1] toggles every 2 cycles for 10 cycles, then holds 1 -> no press_pulse during the bounce. btn_out[1] rises 11 edges after the last toggle is captured.
3. Glitch while pressed: ch0 pressed, btn_raw[0] low for 3 cycles -> btn_out[0] stays 1, no release_pulse. Long counter is not cleared.
4. Long press: hold ch3 -> long_press[3] rises 32 cycles after press_pulse[3]. On release, long_press[3] and btn_out[3] fall on the same edge as release_pulse[3].
5. Simultaneous: btn_raw = 4'b0011 in one cycle -> btn_out goes 0000->0011 on a single edge (the downstream straight-ahead code). press_pulse = 4'b0011 for one cycle.
6. Reset mid-operation: rst for 2 cycles while ch2 is in PCHK and btn_raw[2] stays 1 -> all outputs 0 during reset. press_pulse[2] occurs 11 edges after the first post-reset capture edge.

Source files
------------

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encoding and defaults for the button debouncer
package btn_pkg;

    // Per-channel debounce state; values are fixed so the encoding is stable for debug.
    typedef enum logic [1:0] {
        ST_REL  = 2'd0,
        ST_PCHK = 2'd1,
        ST_PRS  = 2'd2,
        ST_RCHK = 2'd3
    } btn_state_t;

    localparam int DEF_N_BTN = 4;

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button channel: synchronizer, settle-check FSM, long-press timer
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1000000,
    parameter int LONG_CYCLES   = 100000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_btn,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    // A settle count of 1 loads zero, so keep at least one counter bit.
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    // The long counter saturates at LONG_CYCLES, so it must hold that value.
    localparam int LW = $clog2(LONG_CYCLES + 1);

    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [LW-1:0] LONG_MAX    = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] LONG_LAST   = LW'(LONG_CYCLES - 1);

    logic            r_s1;
    logic            r_s2;
    btn_state_t      r_state;
    logic [SW-1:0]   r_settle;
    logic [LW-1:0]   r_long_cnt;

    // Two-flop synchronizer; the FSM only ever looks at r_s2.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    // Settle-check FSM with registered level, pulses and long-press flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_REL;
            r_settle   <= '0;
            r_long_cnt <= '0;
            o_btn      <= 1'b0;
            o_press    <= 1'b0;
            o_release  <= 1'b0;
            o_long     <= 1'b0;
        end else begin
            o_press   <= 1'b0;
            o_release <= 1'b0;
            case (r_state)
                ST_REL: begin
                    o_btn <= 1'b0;
                    if (r_s2) begin
                        r_state  <= ST_PCHK;
                        r_settle <= SETTLE_LOAD;
                    end
                end
                ST_PCHK: begin
                    if (!r_s2) begin
                        r_state <= ST_REL;
                    end else if (r_settle != '0) begin
                        r_settle <= r_settle - 1'b1;
                    end else begin
                        r_state    <= ST_PRS;
                        o_btn      <= 1'b1;
                        o_press    <= 1'b1;
                        r_long_cnt <= '0;
                    end
                end
                ST_PRS: begin
                    o_btn <= 1'b1;
                    if (r_long_cnt != LONG_MAX) begin
                        r_long_cnt <= r_long_cnt + 1'b1;
                    end
                    // The counter steps through LONG_LAST exactly once per hold, and
                    // the flag is sticky until release, so an equality test suffices.
                    if (r_long_cnt == LONG_LAST) begin
                        o_long <= 1'b1;
                    end
                    if (!r_s2) begin
                        r_state  <= ST_RCHK;
                        r_settle <= SETTLE_LOAD;
                    end
                end
                ST_RCHK: begin
                    // Long counter is frozen here; a glitch back to PRS resumes it.
                    if (r_s2) begin
                        r_state <= ST_PRS;
                    end else if (r_settle != '0) begin
                        r_settle <= r_settle - 1'b1;
                    end else begin
                        r_state    <= ST_REL;
                        o_btn      <= 1'b0;
                        o_release  <= 1'b1;
                        o_long     <= 1'b0;
                        r_long_cnt <= '0;
                    end
                end
                default: begin
                    r_state <= ST_REL;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button conditioner: N independent debounce channels
module btn_debounce
    import btn_pkg::*;
#(
    parameter int N_BTN         = DEF_N_BTN,
    parameter int SETTLE_CYCLES = 1000000,
    parameter int LONG_CYCLES   = 100000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_out,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_press
);

    // One fully independent channel per button; equal input timing gives same-edge outputs.
    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .SETTLE_CYCLES(SETTLE_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES)
        ) u_ch (
            .i_clk    (clk),
            .i_rst    (rst),
            .i_raw    (btn_raw[g]),
            .o_btn    (btn_out[g]),
            .o_press  (press_pulse[g]),
            .o_release(release_pulse[g]),
            .o_long   (long_press[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - self-checking bench for btn_debounce
module tb_btn_debounce;

    localparam int N = 4;
    localparam int S = 8;
    localparam int L = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_out;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic [N-1:0] long_press;

    int errors = 0;
    int checks = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    btn_debounce #(
        .N_BTN(N), .SETTLE_CYCLES(S), .LONG_CYCLES(L)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_out(btn_out),
        .press_pulse(press_pulse), .release_pulse(release_pulse), .long_press(long_press)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a level change is accepted once the synchronized input
    // has disagreed with the accepted level on S+1 consecutive edges. Held time
    // counts edges that start pressed with no pending release disagreement.
    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_pp = '0, m_rp = '0, m_long = '0;
    int m_run [N];
    int m_cnt [N];

    always @(posedge clk) begin : model
        logic [N-1:0] lvl, pp, rp, lp;
        int run [N];
        int cnt [N];
        if (rst) begin
            m_s1 <= '0; m_s2 <= '0; m_lvl <= '0; m_pp <= '0; m_rp <= '0; m_long <= '0;
            for (int c = 0; c < N; c++) begin
                m_run[c] <= 0;
                m_cnt[c] <= 0;
            end
        end else begin
            lvl = m_lvl; lp = m_long; pp = '0; rp = '0;
            run = m_run; cnt = m_cnt;
            for (int c = 0; c < N; c++) begin
                if (lvl[c] && run[c] == 0) begin
                    cnt[c]++;
                    if (cnt[c] >= L) lp[c] = 1'b1;
                end
                if (m_s2[c] != lvl[c]) begin
                    run[c]++;
                    if (run[c] == S + 1) begin
                        lvl[c] = m_s2[c];
                        run[c] = 0;
                        cnt[c] = 0;
                        if (m_s2[c]) pp[c] = 1'b1;
                        else begin
                            rp[c] = 1'b1;
                            lp[c] = 1'b0;
                        end
                    end
                end else begin
                    run[c] = 0;
                end
            end
            m_lvl <= lvl; m_pp <= pp; m_rp <= rp; m_long <= lp;
            for (int c = 0; c < N; c++) begin
                m_run[c] <= run[c];
                m_cnt[c] <= cnt[c];
            end
            m_s2 <= m_s1;
            m_s1 <= btn_raw;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_btn_out", btn_out, m_lvl);
            chk("cmp_press_pulse", press_pulse, m_pp);
            chk("cmp_release_pulse", release_pulse, m_rp);
            chk("cmp_long_press", long_press, m_long);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        btn_raw = '0;
        @(posedge clk); #1;
        chk("reset_outputs", {btn_out, press_pulse, release_pulse, long_press}, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int press_e, long_e, pulses, rel_seen, lvl_lost, other;
        logic [N-1:0] tgt, mask;
        int bl, hold;
        rst = 1'b1;
        btn_raw = '0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;

        // Clean press on ch0, then a 3-cycle glitch while held, then a long press.
        do_reset();
        btn_raw = 4'b0001;
        press_e = 0; long_e = 0; pulses = 0; rel_seen = 0; lvl_lost = 0; other = 0;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk); #1;
            if (e == 10) chk("t1_before_press", btn_out, 4'b0000);
            if (e == 11) begin
                chk("t1_btn_out", btn_out, 4'b0001);
                chk("t1_press_pulse", press_pulse, 4'b0001);
                chk("t1_model_pin", m_pp, 4'b0001);
            end
            if (press_pulse[0]) pulses++;
            if (release_pulse[0]) rel_seen++;
            if (e >= 11 && !btn_out[0]) lvl_lost++;
            if (btn_out[3:1] != 3'b000) other++;
            if (long_press[0] && long_e == 0) long_e = e;
            if (e == 12) btn_raw[0] = 1'b0;
            if (e == 15) btn_raw[0] = 1'b1;
        end
        chk("t1_single_pulse", pulses, 1);
        chk("t3_no_release", rel_seen, 0);
        chk("t3_level_held", lvl_lost, 0);
        chk("t1_other_channels", other, 0);
        chk("t3_long_edge", long_e, 46);

        // Bounce on ch1: last toggle captured at edge 9, accept at edge 19.
        do_reset();
        btn_raw = 4'b0010;
        press_e = 0; pulses = 0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk); #1;
            if (press_pulse[1]) begin
                pulses++;
                if (press_e == 0) press_e = e;
            end
            btn_raw[1] = (e + 1 >= 9) ? 1'b1 : (((e / 2) % 2) == 0);
        end
        chk("t2_press_edge", press_e, 19);
        chk("t2_single_pulse", pulses, 1);

        // Long press on ch3 and aligned release.
        do_reset();
        btn_raw = 4'b1000;
        press_e = 0; long_e = 0;
        for (int e = 1; e <= 62; e++) begin
            @(posedge clk); #1;
            if (press_pulse[3] && press_e == 0) press_e = e;
            if (long_press[3] && long_e == 0) long_e = e;
            if (e == 50) btn_raw[3] = 1'b0;
            if (e == 60) chk("t4_before_release", {btn_out[3], long_press[3], release_pulse[3]}, 3'b110);
            if (e == 61) chk("t4_release_edge", {btn_out[3], long_press[3], release_pulse[3]}, 3'b001);
        end
        chk("t4_long_delay", long_e - press_e, L);

        // Simultaneous press on ch0 and ch1.
        do_reset();
        btn_raw = 4'b0011;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            if (e == 10) chk("t5_before", btn_out, 4'b0000);
            if (e == 11) chk("t5_press", {btn_out, press_pulse}, 8'b0011_0011);
            if (e == 12) chk("t5_pulse_end", press_pulse, 4'b0000);
        end

        // Reset while ch2 is in the press check.
        do_reset();
        btn_raw = 4'b0100;
        press_e = 0;
        for (int e = 1; e <= 22; e++) begin
            @(posedge clk); #1;
            if (e == 6 || e == 7)
                chk("t6_in_reset", {btn_out, press_pulse, release_pulse, long_press}, 0);
            if (press_pulse[2] && press_e == 0) press_e = e;
            if (e == 5) rst = 1'b1;
            if (e == 7) rst = 1'b0;
        end
        chk("t6_press_edge", press_e, 18);

        // Randomized bounce/hold segments with occasional resets.
        @(negedge clk);
        for (int seg = 0; seg < 150; seg++) begin
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                repeat (1 + $urandom_range(0, 1)) @(negedge clk);
                rst = 1'b0;
            end
            mask = N'($urandom);
            bl = $urandom_range(0, 12);
            for (int i = 0; i < bl; i++) begin
                btn_raw = (btn_raw & ~mask) | (N'($urandom) & mask);
                @(negedge clk);
            end
            tgt = btn_raw ^ (N'($urandom) & N'($urandom));
            btn_raw = tgt;
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(40, 90) : $urandom_range(2, 30);
            repeat (hold) @(negedge clk);
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
